// File: rtl/feu_pkg.sv
// feu_pkg: traffic light FSM states, lamp encodings and state helpers
package feu_pkg;
   typedef enum logic [2:0] {NS_G, NS_Y, RED1, EW_G, EW_Y, RED2} state_t;
   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;
   function automatic state_t next_state(input state_t s);
      return (s == RED2) ? NS_G : state_t'(s + 3'd1);
   endfunction
   function automatic logic [2:0] ns_lamp(input state_t s);
      return (s == NS_G) ? LAMP_G : (s == NS_Y) ? LAMP_Y : LAMP_R;
   endfunction
   function automatic logic [2:0] ew_lamp(input state_t s);
      return (s == EW_G) ? LAMP_G : (s == EW_Y) ? LAMP_Y : LAMP_R;
   endfunction
   function automatic logic is_red(input state_t s);
      return (s == RED1) || (s == RED2);
   endfunction
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/edge_tick.sv
// edge_tick: synchronizes din into clk and emits a registered one-cycle pulse per rising edge
module edge_tick (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic tick
);
   logic s1, s2, prev;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {s1, s2, prev, tick} <= '0;
      else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
         tick <= s2 & ~prev;
      end
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way signal sequencer paced by slow_clk ticks with pedestrian all-red extension
module traffic_light_ctrl
   import feu_pkg::*;
#(
   parameter int GREEN_T  = 5,
   parameter int YELLOW_T = 2,
   parameter int ALLRED_T = 1,
   parameter int PED_T    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       slow_clk,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       tick,
   output logic       ped_walk
);
   localparam int W = $clog2(max3(GREEN_T, YELLOW_T, ALLRED_T + PED_T)) + 1;
   // terminal counts: a state exits on the tick that arrives at cnt == duration-1
   localparam logic [W-1:0] G_L = W'(GREEN_T - 1);
   localparam logic [W-1:0] Y_L = W'(YELLOW_T - 1);
   localparam logic [W-1:0] R_L = W'(ALLRED_T - 1);
   localparam logic [W-1:0] P_L = W'(ALLRED_T + PED_T - 1);
   state_t         state, state_n;
   logic [W-1:0]   cnt, cnt_n, last;
   logic [2:0]     ns_n, ew_n;
   logic           ped_pend, ped_pend_n, ped_walk_n, pend_eff, adv;
   edge_tick u_edge_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (slow_clk),
      .tick (tick)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= NS_G;
         cnt      <= '0;
         ns_light <= LAMP_G;
         ew_light <= LAMP_R;
         ped_pend <= 1'b0;
         ped_walk <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         ns_light <= ns_n;
         ew_light <= ew_n;
         ped_pend <= ped_pend_n;
         ped_walk <= ped_walk_n;
      end
   always_comb begin
      last       = (state == NS_G || state == EW_G) ? G_L :
                   (state == NS_Y || state == EW_Y) ? Y_L : ped_walk ? P_L : R_L;
      adv        = tick && (cnt == last);
      state_n    = adv ? next_state(state) : state;
      cnt_n      = adv ? '0 : cnt + W'(tick);
      pend_eff   = ped_pend | ped_req;
      ped_pend_n = (adv && is_red(state_n)) ? 1'b0 : pend_eff;
      ped_walk_n = adv ? (is_red(state_n) && pend_eff) : ped_walk;
      ns_n       = ns_lamp(state_n);
      ew_n       = ew_lamp(state_n);
   end
endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter GREEN_T, default 5: green duration in slow ticks, >=1.
REQ-002 Parameter YELLOW_T, default 2: yellow duration in slow ticks, >=1.
REQ-003 Parameter ALLRED_T, default 1: all-red duration in slow ticks, >=1.
REQ-004 Parameter PED_T, default 3: extra all-red ticks granted to a pedestrian request, >=1.
REQ-005 Port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port slow_clk, input, 1: divided clock from the divider block, sampled as data in the clk domain.
REQ-008 Port ped_req, input, 1: pedestrian request, level, any length >= 1 clk cycle.
REQ-009 Port ns_light, output, 3: north-south lamps, one-hot {R,Y,G}, bit2 = R.
REQ-010 Port ew_light, output, 3: east-west lamps, one-hot {R,Y,G}.
REQ-011 Port tick, output, 1: one-cycle pulse per slow_clk rising edge.
REQ-012 Port ped_walk, output, 1: pedestrian walk indication.

Function
REQ-013 slow_clk SHALL pass through a 2-flop synchronizer, then a previous-value register; tick = sync2 & ~prev, registered.
REQ-014 With slow_clk first sampled high at clk edge k, tick SHALL be high exactly during the cycle after edge k+2, for one cycle only.
REQ-015 Glitches on slow_clk shorter than one clk period SHALL produce at most one tick.
REQ-016 FSM states: NS_G, NS_Y, RED1, EW_G, EW_Y, RED2; cyclic order NS_G->NS_Y->RED1->EW_G->EW_Y->RED2->NS_G.
REQ-017 Lamps: NS_G ns=G ew=R; NS_Y ns=Y ew=R; EW_G ns=R ew=G; EW_Y ns=R ew=Y; RED1/RED2 both R.
REQ-018 Lamp outputs SHALL be registered and change in the same cycle as the state register.
REQ-019 Tick counter cnt SHALL reset to 0 on every state entry and increment only on tick.
REQ-020 A state of duration D SHALL exit on the tick arriving when cnt == D-1; transition effective at that clk edge.
REQ-021 Counter width SHALL be $clog2 of the largest of GREEN_T, YELLOW_T, ALLRED_T+PED_T, plus 1; no wrap possible.
REQ-022 ped_req SHALL set a sticky ped_pend flag; cleared on entry to RED1 or RED2 when consumed.
REQ-023 On entry to RED1/RED2 with ped_pend set, all-red duration SHALL be ALLRED_T+PED_T and ped_walk SHALL be 1 for that whole state.
REQ-024 ped_req asserted during an all-red with ped_walk active SHALL remain pending for the next all-red.
REQ-025 Two lamps SHALL never both be non-red simultaneously; never zero or multiple bits hot per output.
REQ-026 Without ticks, state and outputs SHALL hold indefinitely.

Reset
REQ-027 rst_n low SHALL immediately force: state NS_G, cnt 0, ns_light 001, ew_light 100, tick 0, ped_walk 0, ped_pend 0, sync/prev regs 0.
REQ-028 Reset mid-state SHALL abort the cycle; after release, sequencing restarts from NS_G with full GREEN_T.
REQ-029 slow_clk high at reset release SHALL yield a tick 3 cycles later (prev = 0).

Structure
REQ-030 Package feu_pkg SHALL hold the state enum and lamp constants LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001.
REQ-031 Synchronizer and edge detector SHALL be sub-module edge_tick (clk, rst_n, din, tick).

Verification (GREEN_T=3, YELLOW_T=1, ALLRED_T=1, PED_T=2, slow_clk period 8 clk)
REQ-032 slow_clk rises at edge 10 -> tick high only in cycle after edge 12; 1 tick per slow period.
REQ-033 Free run, no ped_req -> NS_G 3 ticks, NS_Y 1, RED1 1, EW_G 3, EW_Y 1, RED2 1; 10-tick period.
REQ-034 ped_req 1-cycle pulse during NS_G tick 1 -> RED1 lasts 3 ticks, ped_walk=1 throughout; RED2 lasts 1 tick.
REQ-035 rst_n low for 1 cycle in EW_G -> ns=001, ew=100 same cycle; NS_G then lasts 3 ticks.
REQ-036 slow_clk held constant 100 cycles -> no tick, outputs unchanged; lamp one-hot/mutual-red assertions hold throughout.
